// File: rtl/fft_loader_pkg.sv
// Shared types and helpers for the FFT input loader and its address-path blocks.
package fft_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RE   = 2'd1,
        ST_IM   = 2'd2
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 1024;
    localparam int unsigned TMO_W           = $clog2(TIMEOUT_DEFAULT + 1);
    localparam int unsigned BITREV_MAX      = 32;

    // Timeout counter width; a disabled timeout still gets a 1-bit counter.
    function automatic int unsigned tmo_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

    // Reverse the low w bits of v; bits above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < BITREV_MAX; i++) begin
            if (i < w) r[i[4:0]] = v[5'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Byte-stream input and FFT-memory write port of the input loader.
interface fft_input_loader_if #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned SIZE      = 4
);
    logic [7:0]           byte_i;
    logic                 byte_valid_i;
    logic                 bitrev_en_i;
    logic                 sync_i;
    logic [BIT_WIDTH-1:0] re_o;
    logic [BIT_WIDTH-1:0] im_o;
    logic [SIZE-1:0]      addr_o;
    logic                 en_o;
    logic                 start_flag;
    logic                 timeout_o;

    modport master (
        output byte_i, byte_valid_i, bitrev_en_i, sync_i,
        input  re_o, im_o, addr_o, en_o, start_flag, timeout_o
    );

    modport slave (
        input  byte_i, byte_valid_i, bitrev_en_i, sync_i,
        output re_o, im_o, addr_o, en_o, start_flag, timeout_o
    );
endinterface

// File: rtl/bit_reverse.sv
// Combinational SIZE-bit bit reversal, shared by the loader and the output reorder block.
module bit_reverse
    import fft_loader_pkg::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic [SIZE-1:0] val,
    output logic [SIZE-1:0] rev_c
);
    assign rev_c = SIZE'(bitrev(32'(val), SIZE));
endmodule

// File: rtl/fft_input_loader.sv
// Packs UART bytes into signed complex samples and writes them to the FFT input
// memory in natural or bit-reversed order, with frame resync and inter-byte timeout.
module fft_input_loader
    import fft_loader_pkg::*;
#(
    parameter int unsigned BIT_WIDTH      = 32,
    parameter int unsigned N              = 16,
    parameter int unsigned SIZE           = 4,
    parameter int unsigned BYTES_PER_COMP = 1,
    parameter int unsigned FRAC_BITS      = 8,
    parameter int unsigned TIMEOUT        = 1024
) (
    input logic               clk,
    input logic               rst,
    fft_input_loader_if.slave bus
);
    localparam int unsigned CW = 8 * BYTES_PER_COMP;
    localparam int unsigned TW = tmo_width(TIMEOUT);
    localparam int unsigned BW = (BYTES_PER_COMP > 1) ? $clog2(BYTES_PER_COMP) : 1;

    state_t               state_q, state_d, cur_state;
    logic [BW-1:0]        bcnt_q, bcnt_d, cur_bcnt;
    logic [SIZE-1:0]      idx_q, idx_d, cur_idx, idx_rev;
    logic [CW-1:0]        sh_q, sh_d, sh_shift, re_hold_q, re_hold_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic                 mode_q, mode_d;
    logic [BIT_WIDTH-1:0] re_q, re_d, im_q, im_d;
    logic [SIZE-1:0]      addr_q, addr_d;
    logic                 en_q, en_d, start_q, start_d, tmo_q, tmo_d, last_q, last_d;
    logic                 byte_last;

    // Sign-extend the component to BIT_WIDTH and append FRAC_BITS zeros.
    function automatic logic [BIT_WIDTH-1:0] fmt(input logic [CW-1:0] c);
        logic signed [BIT_WIDTH-1:0] e;
        e = BIT_WIDTH'($signed(c));
        return e << FRAC_BITS;
    endfunction

    // A resync makes this cycle behave as if the loader were idle at sample 0.
    assign cur_state = bus.sync_i ? ST_IDLE : state_q;
    assign cur_bcnt  = bus.sync_i ? '0 : bcnt_q;
    assign cur_idx   = bus.sync_i ? '0 : idx_q;
    assign sh_shift  = CW'({sh_q, bus.byte_i});
    assign byte_last = (cur_bcnt == BW'(BYTES_PER_COMP - 1));

    bit_reverse #(.SIZE(SIZE)) u_rev (
        .val   (cur_idx),
        .rev_c (idx_rev)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        re_hold_d = re_hold_q;
        tcnt_d    = tcnt_q;
        mode_d    = mode_q;
        re_d      = re_q;
        im_d      = im_q;
        addr_d    = addr_q;
        en_d      = 1'b0;
        tmo_d     = 1'b0;
        last_d    = 1'b0;
        start_d   = last_q;

        if (bus.sync_i) begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
            idx_d   = '0;
            tcnt_d  = '0;
        end

        if (bus.byte_valid_i) begin
            tcnt_d = '0;
            sh_d   = sh_shift;
            case (cur_state)
                ST_IDLE: begin
                    if (cur_idx == '0) mode_d = bus.bitrev_en_i;
                    if (BYTES_PER_COMP == 1) begin
                        re_hold_d = sh_shift;
                        state_d   = ST_IM;
                    end else begin
                        bcnt_d  = BW'(1);
                        state_d = ST_RE;
                    end
                end
                ST_RE: begin
                    if (byte_last) begin
                        re_hold_d = sh_shift;
                        bcnt_d    = '0;
                        state_d   = ST_IM;
                    end else begin
                        bcnt_d = cur_bcnt + 1'b1;
                    end
                end
                ST_IM: begin
                    if (byte_last) begin
                        re_d    = fmt(re_hold_q);
                        im_d    = fmt(sh_shift);
                        addr_d  = mode_q ? idx_rev : cur_idx;
                        en_d    = 1'b1;
                        last_d  = (cur_idx == SIZE'(N - 1));
                        idx_d   = cur_idx + 1'b1;
                        bcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        bcnt_d = cur_bcnt + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (!bus.sync_i && state_q != ST_IDLE && TIMEOUT != 0) begin
            if (32'(tcnt_q) + 1 == TIMEOUT) begin
                state_d = ST_IDLE;
                bcnt_d  = '0;
                tcnt_d  = '0;
                tmo_d   = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q    <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            re_hold_q <= '0;
            tcnt_q    <= '0;
            mode_q    <= 1'b1;
            re_q      <= '0;
            im_q      <= '0;
            addr_q    <= '0;
            en_q      <= 1'b0;
            start_q   <= 1'b0;
            tmo_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            bcnt_q    <= bcnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            re_hold_q <= re_hold_d;
            tcnt_q    <= tcnt_d;
            mode_q    <= mode_d;
            re_q      <= re_d;
            im_q      <= im_d;
            addr_q    <= addr_d;
            en_q      <= en_d;
            start_q   <= start_d;
            tmo_q     <= tmo_d;
            last_q    <= last_d;
        end
    end

    assign bus.re_o       = re_q;
    assign bus.im_o       = im_q;
    assign bus.addr_o     = addr_q;
    assign bus.en_o       = en_q;
    assign bus.start_flag = start_q;
    assign bus.timeout_o  = tmo_q;
endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: one-byte and two-byte component instances.
module tb_fft_input_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_input_loader_if #(.BIT_WIDTH(32), .SIZE(4)) b0 ();
    fft_input_loader_if #(.BIT_WIDTH(32), .SIZE(4)) b1 ();

    fft_input_loader #(.BIT_WIDTH(32), .N(16), .SIZE(4), .BYTES_PER_COMP(1),
                       .FRAC_BITS(8), .TIMEOUT(20)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    fft_input_loader #(.BIT_WIDTH(32), .N(16), .SIZE(4), .BYTES_PER_COMP(2),
                       .FRAC_BITS(8), .TIMEOUT(20)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] re;
        logic [31:0] im;
        int          cyc;
    } emit_t;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    overlap = 0;
    emit_t emits[$];
    int    starts[$];
    logic [3:0] rev_tab [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                 4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe and frame-complete pulse of the one-byte instance.
    always @(negedge clk) begin
        if (rst == 1'b0) begin
            if (b0.en_o) begin
                emit_t e;
                e.addr = b0.addr_o; e.re = b0.re_o; e.im = b0.im_o; e.cyc = cyc;
                emits.push_back(e);
            end
            if (b0.start_flag) starts.push_back(cyc);
            if (b0.en_o && b0.start_flag) overlap++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [7:0] b);
        b0.byte_i = b; b0.byte_valid_i = 1'b1;
        tick();
        b0.byte_valid_i = 1'b0;
    endtask

    task automatic send1(input logic [7:0] b);
        b1.byte_i = b; b1.byte_valid_i = 1'b1;
        tick();
        b1.byte_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        emits.delete();
        starts.delete();
    endtask

    task automatic test_reset();
        b0.byte_i = 8'h5A; b0.byte_valid_i = 1'b1;
        do_reset();
        b0.byte_valid_i = 1'b0;
        n_vec++; if (b0.re_o !== 32'h0) begin n_err++; $display("FAIL reset_re: got %h want 0", b0.re_o); end
        n_vec++; if (b0.im_o !== 32'h0) begin n_err++; $display("FAIL reset_im: got %h want 0", b0.im_o); end
        n_vec++; if (b0.addr_o !== 4'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", b0.addr_o); end
        n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", b0.en_o); end
        n_vec++; if (b0.start_flag !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", b0.start_flag); end
        n_vec++; if (b0.timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", b0.timeout_o); end
    endtask

    task automatic test_single();
        send0(8'h7F);
        n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL single_early_en: got %b want 0", b0.en_o); end
        send0(8'h80);
        n_vec++; if (b0.en_o !== 1'b1) begin n_err++; $display("FAIL single_en: got %b want 1", b0.en_o); end
        n_vec++; if (b0.re_o !== 32'h00007F00) begin n_err++; $display("FAIL single_re: got %h want 00007f00", b0.re_o); end
        n_vec++; if (b0.im_o !== 32'hFFFF8000) begin n_err++; $display("FAIL single_im: got %h want ffff8000", b0.im_o); end
        n_vec++; if (b0.addr_o !== 4'h0) begin n_err++; $display("FAIL single_addr: got %h want 0", b0.addr_o); end
        tick();
        n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL single_en_drop: got %b want 0", b0.en_o); end
        n_vec++; if (b0.re_o !== 32'h00007F00) begin n_err++; $display("FAIL single_re_hold: got %h want 00007f00", b0.re_o); end
    endtask

    task automatic test_full_frame();
        do_reset();
        b0.bitrev_en_i = 1'b1;
        for (int i = 0; i < 32; i++) send0(8'(i));
        tick(); tick(); tick();
        n_vec++; if (emits.size() != 16) begin n_err++; $display("FAIL frame_count: got %0d want 16", emits.size()); end
        for (int k = 0; k < 16; k++) begin
            if (k < emits.size()) begin
                n_vec++; if (emits[k].addr !== rev_tab[k]) begin n_err++; $display("FAIL frame_addr[%0d]: got %0d want %0d", k, emits[k].addr, rev_tab[k]); end
                n_vec++; if (emits[k].re !== (32'(2*k) << 8)) begin n_err++; $display("FAIL frame_re[%0d]: got %h want %h", k, emits[k].re, 32'(2*k) << 8); end
                n_vec++; if (emits[k].im !== (32'(2*k+1) << 8)) begin n_err++; $display("FAIL frame_im[%0d]: got %h want %h", k, emits[k].im, 32'(2*k+1) << 8); end
            end
        end
        n_vec++; if (starts.size() != 1) begin n_err++; $display("FAIL frame_start_count: got %0d want 1", starts.size()); end
        if (starts.size() == 1 && emits.size() == 16) begin
            n_vec++; if (starts[0] != emits[15].cyc + 1) begin n_err++; $display("FAIL frame_start_cycle: got %0d want %0d", starts[0], emits[15].cyc + 1); end
        end
        n_vec++; if (overlap != 0) begin n_err++; $display("FAIL frame_overlap: got %0d want 0", overlap); end
        send0(8'hA0);
        send0(8'hA1);
        n_vec++; if (b0.en_o !== 1'b1) begin n_err++; $display("FAIL next_frame_en: got %b want 1", b0.en_o); end
        n_vec++; if (b0.addr_o !== 4'h0) begin n_err++; $display("FAIL next_frame_addr: got %h want 0", b0.addr_o); end
        n_vec++; if (b0.re_o !== 32'hFFFFA000) begin n_err++; $display("FAIL next_frame_re: got %h want ffffa000", b0.re_o); end
    endtask

    task automatic test_natural();
        do_reset();
        b0.bitrev_en_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send0(8'(i + 64));
            if (i == 11) b0.bitrev_en_i = 1'b1;
        end
        for (int i = 0; i < 32; i++) send0(8'(i));
        tick(); tick(); tick();
        n_vec++; if (emits.size() != 32) begin n_err++; $display("FAIL natural_count: got %0d want 32", emits.size()); end
        for (int k = 0; k < 32; k++) begin
            if (k < emits.size()) begin
                logic [3:0] want;
                want = (k < 16) ? 4'(k) : rev_tab[k - 16];
                n_vec++; if (emits[k].addr !== want) begin n_err++; $display("FAIL natural_addr[%0d]: got %0d want %0d", k, emits[k].addr, want); end
            end
        end
        n_vec++; if (starts.size() != 2) begin n_err++; $display("FAIL natural_starts: got %0d want 2", starts.size()); end
        n_vec++; if (overlap != 0) begin n_err++; $display("FAIL natural_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_timeout();
        do_reset();
        b0.bitrev_en_i = 1'b1;
        send0(8'h03);
        send0(8'h04);
        send0(8'h55);
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++; if (b0.timeout_o !== (k == 20)) begin n_err++; $display("FAIL timeout_pulse[%0d]: got %b want %b", k, b0.timeout_o, (k == 20)); end
            n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL timeout_en[%0d]: got %b want 0", k, b0.en_o); end
        end
        send0(8'h01);
        n_vec++; if (b0.timeout_o !== 1'b0) begin n_err++; $display("FAIL timeout_single: got %b want 0", b0.timeout_o); end
        send0(8'h02);
        n_vec++; if (b0.en_o !== 1'b1) begin n_err++; $display("FAIL timeout_resume_en: got %b want 1", b0.en_o); end
        n_vec++; if (b0.re_o !== 32'h00000100) begin n_err++; $display("FAIL timeout_resume_re: got %h want 00000100", b0.re_o); end
        n_vec++; if (b0.im_o !== 32'h00000200) begin n_err++; $display("FAIL timeout_resume_im: got %h want 00000200", b0.im_o); end
        n_vec++; if (b0.addr_o !== 4'd8) begin n_err++; $display("FAIL timeout_resume_addr: got %0d want 8", b0.addr_o); end
        send0(8'h66);
        for (int k = 1; k <= 19; k++) tick();
        send0(8'h77);
        n_vec++; if (b0.timeout_o !== 1'b0) begin n_err++; $display("FAIL byte_wins_timeout: got %b want 0", b0.timeout_o); end
        n_vec++; if (b0.en_o !== 1'b1) begin n_err++; $display("FAIL byte_wins_en: got %b want 1", b0.en_o); end
        n_vec++; if (b0.addr_o !== 4'd4) begin n_err++; $display("FAIL byte_wins_addr: got %0d want 4", b0.addr_o); end
        n_vec++; if (b0.re_o !== 32'h00006600) begin n_err++; $display("FAIL byte_wins_re: got %h want 00006600", b0.re_o); end
        tick();
        n_vec++; if (b0.timeout_o !== 1'b0) begin n_err++; $display("FAIL byte_wins_late: got %b want 0", b0.timeout_o); end
    endtask

    task automatic test_multibyte();
        do_reset();
        send1(8'h12);
        send1(8'h34);
        n_vec++; if (b1.en_o !== 1'b0) begin n_err++; $display("FAIL mb_early_en: got %b want 0", b1.en_o); end
        send1(8'hFE);
        send1(8'hDC);
        n_vec++; if (b1.en_o !== 1'b1) begin n_err++; $display("FAIL mb_en: got %b want 1", b1.en_o); end
        n_vec++; if (b1.re_o !== 32'h00123400) begin n_err++; $display("FAIL mb_re: got %h want 00123400", b1.re_o); end
        n_vec++; if (b1.im_o !== 32'hFFFEDC00) begin n_err++; $display("FAIL mb_im: got %h want fffedc00", b1.im_o); end
        n_vec++; if (b1.addr_o !== 4'd0) begin n_err++; $display("FAIL mb_addr: got %0d want 0", b1.addr_o); end
        send1(8'h80); send1(8'h00); send1(8'h7F); send1(8'hFF);
        n_vec++; if (b1.re_o !== 32'hFF800000) begin n_err++; $display("FAIL mb2_re: got %h want ff800000", b1.re_o); end
        n_vec++; if (b1.im_o !== 32'h007FFF00) begin n_err++; $display("FAIL mb2_im: got %h want 007fff00", b1.im_o); end
        n_vec++; if (b1.addr_o !== 4'd8) begin n_err++; $display("FAIL mb2_addr: got %0d want 8", b1.addr_o); end
    endtask

    task automatic test_resync();
        do_reset();
        for (int i = 0; i < 14; i++) send0(8'(i + 1));
        send0(8'h99);
        b0.sync_i = 1'b1;
        send0(8'h11);
        b0.sync_i = 1'b0;
        n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL sync_en: got %b want 0", b0.en_o); end
        n_vec++; if (b0.timeout_o !== 1'b0) begin n_err++; $display("FAIL sync_timeout: got %b want 0", b0.timeout_o); end
        send0(8'h22);
        n_vec++; if (b0.en_o !== 1'b1) begin n_err++; $display("FAIL sync_emit_en: got %b want 1", b0.en_o); end
        n_vec++; if (b0.addr_o !== 4'd0) begin n_err++; $display("FAIL sync_addr: got %0d want 0", b0.addr_o); end
        n_vec++; if (b0.re_o !== 32'h00001100) begin n_err++; $display("FAIL sync_re: got %h want 00001100", b0.re_o); end
        n_vec++; if (b0.im_o !== 32'h00002200) begin n_err++; $display("FAIL sync_im: got %h want 00002200", b0.im_o); end
        send0(8'h05);
        send0(8'h06);
        n_vec++; if (b0.addr_o !== 4'd8) begin n_err++; $display("FAIL sync_next_addr: got %0d want 8", b0.addr_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send0(8'h01); send0(8'h02); send0(8'h03); send0(8'h04);
        send0(8'h33);
        b0.byte_i = 8'h44; b0.byte_valid_i = 1'b1; rst = 1'b1;
        tick();
        b0.byte_valid_i = 1'b0; rst = 1'b0;
        n_vec++; if (b0.re_o !== 32'h0) begin n_err++; $display("FAIL rstmid_re: got %h want 0", b0.re_o); end
        n_vec++; if (b0.im_o !== 32'h0) begin n_err++; $display("FAIL rstmid_im: got %h want 0", b0.im_o); end
        n_vec++; if (b0.addr_o !== 4'h0) begin n_err++; $display("FAIL rstmid_addr: got %h want 0", b0.addr_o); end
        n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL rstmid_en: got %b want 0", b0.en_o); end
        n_vec++; if (b0.start_flag !== 1'b0) begin n_err++; $display("FAIL rstmid_start: got %b want 0", b0.start_flag); end
        n_vec++; if (b0.timeout_o !== 1'b0) begin n_err++; $display("FAIL rstmid_timeout: got %b want 0", b0.timeout_o); end
        tick();
        n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL rstmid_no_emit: got %b want 0", b0.en_o); end
        send0(8'h09);
        n_vec++; if (b0.en_o !== 1'b0) begin n_err++; $display("FAIL rstmid_first_byte: got %b want 0", b0.en_o); end
        send0(8'h0A);
        n_vec++; if (b0.en_o !== 1'b1) begin n_err++; $display("FAIL rstmid_after_en: got %b want 1", b0.en_o); end
        n_vec++; if (b0.addr_o !== 4'd0) begin n_err++; $display("FAIL rstmid_after_addr: got %0d want 0", b0.addr_o); end
        n_vec++; if (b0.re_o !== 32'h00000900) begin n_err++; $display("FAIL rstmid_after_re: got %h want 00000900", b0.re_o); end
    endtask

    initial begin
        rst = 1'b1;
        b0.byte_i = 8'h00; b0.byte_valid_i = 1'b0; b0.bitrev_en_i = 1'b1; b0.sync_i = 1'b0;
        b1.byte_i = 8'h00; b1.byte_valid_i = 1'b0; b1.bitrev_en_i = 1'b1; b1.sync_i = 1'b0;
        test_reset();
        test_single();
        test_full_frame();
        test_natural();
        test_timeout();
        test_multibyte();
        test_resync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

- Assembles a stream of 8-bit bytes (UART receiver output) into complex samples of `BIT_WIDTH` bits.
- Attaches a write address to each sample: bit-reversed or natural order, chosen at run time.
- Presents each sample to the FFT input memory as a one-cycle write strobe.
- Parametrised successor of the single-byte loader: adds multi-byte components, run-time order selection, frame resync, inter-byte timeout and a one-cycle frame-complete pulse.

## Interface
- `BIT_WIDTH`, 32, width of `re_o` / `im_o`. Must satisfy `BIT_WIDTH >= 8*BYTES_PER_COMP + FRAC_BITS`.
- `N`, 16, samples per frame; power of two.
- `SIZE`, 4, address width; equals log2(N).
- `BYTES_PER_COMP`, 1, bytes per real or imaginary component; range 1..4.
- `FRAC_BITS`, 8, zero bits appended below the received integer.
- `TIMEOUT`, 1024, idle cycles that abandon a partial sample; 0 disables the timeout.
- `clk` in 1 — the single clock; all logic on the rising edge.
- `rst` in 1 — reset, synchronous and active-high.
- `byte_i` in 8 — received byte, two's-complement fragment.
- `byte_valid_i` in 1 — one-cycle strobe; `byte_i` is valid in that cycle.
- `bitrev_en_i` in 1 — 1 = bit-reversed addresses, 0 = natural order.
- `sync_i` in 1 — frame resync: drop any partial sample and set the sample index to 0.
- `re_o` out BIT_WIDTH — real part, signed.
- `im_o` out BIT_WIDTH — imaginary part, signed.
- `addr_o` out SIZE — write address for the current sample.
- `en_o` out 1 — one-cycle write strobe qualifying `re_o`, `im_o` and `addr_o`.
- `start_flag` out 1 — one-cycle pulse: frame complete, FFT may start.
- `timeout_o` out 1 — one-cycle pulse: a partial sample was discarded.

## Operation
- FSM states:
  - IDLE: no bytes of the current sample held.
  - RE: collecting the real component.
  - IM: collecting the imaginary component.
- Byte counter `bcnt`, range 0..BYTES_PER_COMP-1. Sample index `idx`, SIZE bits.
- Byte order: real component first, then imaginary. Within a component, MSB byte first, shifted into an `8*BYTES_PER_COMP`-bit register.
- Transitions:
  - IDLE→RE on a byte, except when BYTES_PER_COMP=1, where IDLE→IM directly.
  - RE→IM when the last real byte is accepted.
  - IM→IDLE when the last imaginary byte is accepted; this is the emit event.
- Sample formatting:
  - Output = `{sign-extension, component, FRAC_BITS zeros}`.
  - The extension copies the component MSB up to BIT_WIDTH.
- Emit event:
  - Next cycle: `re_o` and `im_o` take the formatted values, `addr_o` takes `bitrev(idx)` or `idx`, and `en_o`=1 for exactly one cycle.
  - `idx` increments, wrapping N-1→0.
  - When the emitted `idx` was N-1, `start_flag`=1 in the cycle after that `en_o`.
- Order mode: `bitrev_en_i` is sampled when the first byte of sample 0 is accepted and held for the whole frame. Changes mid-frame are ignored.
- `re_o`, `im_o` and `addr_o` hold their last values between strobes.
- Timeout:
  - Counter clears on every accepted byte and counts only in RE/IM.
  - On reaching TIMEOUT: discard the partial sample, go to IDLE, leave `idx` unchanged, pulse `timeout_o` for one cycle.
  - A byte arriving in the same cycle wins: no timeout, byte accepted.
- `sync_i`:
  - Clears `bcnt`, `idx`, the timeout counter and the FSM state.
  - If `byte_valid_i` is high in the same cycle, that byte is accepted as byte 0 of sample 0 of the new frame.
  - No `timeout_o` is generated by a resync.
- `rst` has highest priority and aborts any partial sample or frame.

## Timing
- Reset values: `re_o`=0, `im_o`=0, `addr_o`=0, `en_o`=0, `start_flag`=0, `timeout_o`=0; state IDLE; `bcnt`=0; `idx`=0; stored mode = bit-reversed.
- Latency: `en_o` rises 1 cycle after the strobe of the final byte of a sample.
- Throughput: no dead cycles. Bytes on consecutive cycles are all accepted, including a byte in the same cycle as `en_o` or `start_flag`.
- `start_flag` never coincides with `en_o`. It is always the cycle after the N-th strobe.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `fft_loader_pkg` holds:
  - the FSM state encoding (IDLE/RE/IM);
  - a `bitrev` function parametrised by width;
  - a localparam for the timeout counter width, `$clog2(TIMEOUT+1)`.
- One sub-module, `bit_reverse` (parameter SIZE, purely combinational). Instantiated on the address path so it can be reused by the output-side reorder block.

## Test plan
Defaults unless stated: N=16, SIZE=4, BYTES_PER_COMP=1, BIT_WIDTH=32, FRAC_BITS=8.
- Single sample:
  - Stimulus: bytes 0x7F then 0x80.
  - Required: one cycle after the 2nd strobe, `re_o`=0x00007F00, `im_o`=0xFFFF8000, `addr_o`=0, `en_o`=1 for one cycle.
- Full frame, bit-reversed:
  - Stimulus: `bitrev_en_i`=1, 32 back-to-back bytes.
  - Required: `addr_o` sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15; `start_flag` one cycle after the 16th `en_o`; the next frame's first address is 0.
- Natural order and mode latching:
  - Stimulus: `bitrev_en_i`=0 at frame start, toggled to 1 after sample 5.
  - Required: addresses 0..15 in order; the following frame uses bit-reversed order.
- Timeout (TIMEOUT=20):
  - Stimulus: one byte, then 20 idle cycles, then bytes 0x01, 0x02.
  - Required: `timeout_o` pulse 20 cycles after the first byte; the new sample emits `re_o`=0x00000100, `im_o`=0x00000200 with the same `addr_o` as the discarded sample would have had.
- Multi-byte components (BYTES_PER_COMP=2):
  - Stimulus: bytes 0x12, 0x34, 0xFE, 0xDC.
  - Required: `re_o`=0x00123400, `im_o`=0xFFFEDC00.
- Resync and reset:
  - Stimulus: `sync_i` together with a byte after 7 samples, then one more byte.
  - Required: the next emitted sample uses `addr_o`=0.
  - Stimulus: `rst` asserted mid-sample.
  - Required: all outputs return to reset values on the next edge; no `en_o` from the partial sample.
